lsu_nbload_ctl: RTL and testbench

Controller for the LSU non-blocking load buffer (load CAM).
- Allocates a tag to each issuing load and records its destination rd.
- Buffers out-of-order bus returns per tag.
- Arbitrates buffered results onto the single shared integer-register writeback port.
- Provides a pending-rd hazard check to decode. Sits between the LSU bus interface and the decode/writeback stage.

---
 rtl/swerv_types.sv | 19 +
 rtl/lsu_nbload_rr_arb.sv | 32 +++
 rtl/lsu_nbload_ctl.sv | 193 +++++++++++++++++++
 tb/tb_lsu_nbload_ctl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/swerv_types.sv
// Shared types for the LSU non-blocking load buffer.
//   nbload_state_t : per-entry lifecycle (IDLE, PEND, DONE, KILL)
//   nbload_entry_t : one buffer entry (state, destination rd, buffered data)
package swerv_types;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // free for allocation
    PEND = 2'd1,  // issued, awaiting bus return
    DONE = 2'd2,  // data buffered, awaiting writeback
    KILL = 2'd3   // flushed while in flight; return will be discarded
  } nbload_state_t;

  typedef struct packed {
    nbload_state_t state;
    logic [4:0]    rd;
    logic [31:0]   data;
  } nbload_entry_t;

endpackage

// File: rtl/lsu_nbload_rr_arb.sv
// Round-robin picker for the non-blocking load buffer writeback.
// Searches req_i starting at index ptr_i (wrapping) and returns the first set bit.
//   req_i       : per-entry request vector
//   ptr_i       : index where the search starts
//   gnt_valid_o : some request found
//   gnt_idx_o   : index of the granted request
module lsu_nbload_rr_arb #(
  parameter int unsigned NB_DEPTH = 4,
  parameter int unsigned TAG_W    = 2
) (
  input  logic [NB_DEPTH-1:0] req_i,
  input  logic [TAG_W-1:0]    ptr_i,
  output logic                gnt_valid_o,
  output logic [TAG_W-1:0]    gnt_idx_o
);

  logic [TAG_W-1:0] idx;

  always_comb begin
    gnt_valid_o = 1'b0;
    gnt_idx_o   = '0;
    idx         = '0;
    for (int unsigned i = 0; i < NB_DEPTH; i++) begin
      idx = TAG_W'((32'(ptr_i) + i) % NB_DEPTH);
      if (!gnt_valid_o && req_i[idx]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = idx;
      end
    end
  end

endmodule

// File: rtl/lsu_nbload_ctl.sv
// LSU non-blocking load buffer controller (load CAM).
// Allocates a tag per issuing load, buffers out-of-order bus returns, arbitrates buffered
// results onto the single integer writeback port and reports pending-rd hazards to decode.
// Optional feature macro: LSU_NBLOAD_ERR_EN (bus-error drop and protocol-violation pulse).
// Ports:
//   clk, rst_l                  : clock, synchronous active-low reset
//   alloc_req/rd -> gnt/tag     : tag allocation for an issuing load
//   ret_valid/tag/data/error    : bus read returns
//   flush                       : kill all outstanding loads
//   wb_valid/ready/rd/data/tag  : writeback handshake
//   chk_rs1/rs2 -> chk_hit      : decode hazard check against live entries
//   full, empty                 : buffer occupancy
//   err_valid, err_tag          : one-cycle error pulse (0 unless LSU_NBLOAD_ERR_EN)
module lsu_nbload_ctl #(
  parameter int unsigned NB_DEPTH = 4,
  parameter int unsigned TAG_W    = 2
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             alloc_req,
  input  logic [4:0]       alloc_rd,
  output logic             alloc_gnt,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             ret_valid,
  input  logic [TAG_W-1:0] ret_tag,
  input  logic [31:0]      ret_data,
  input  logic             ret_error,
  input  logic             flush,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [4:0]       wb_rd,
  output logic [31:0]      wb_data,
  output logic [TAG_W-1:0] wb_tag,
  input  logic [4:0]       chk_rs1,
  input  logic [4:0]       chk_rs2,
  output logic             chk_hit,
  output logic             full,
  output logic             empty,
  output logic             err_valid,
  output logic [TAG_W-1:0] err_tag
);

  import swerv_types::*;

  nbload_entry_t entry_q [NB_DEPTH];
  nbload_entry_t entry_d [NB_DEPTH];
  logic [TAG_W-1:0] ptr_q, ptr_d;

  logic [NB_DEPTH-1:0] idle_vec, done_vec, waw_vec, rs1_vec, rs2_vec;
  logic                waw;
  logic                pick_valid;
  logic [TAG_W-1:0]    pick_idx;
  logic [4:0]          pick_rd;
  logic                pend_err;

  // Occupancy and CAM compares against registered state only.
  always_comb begin
    idle_vec = '0;
    done_vec = '0;
    waw_vec  = '0;
    rs1_vec  = '0;
    rs2_vec  = '0;
    for (int i = 0; i < NB_DEPTH; i++) begin
      idle_vec[i] = (entry_q[i].state == IDLE);
      done_vec[i] = (entry_q[i].state == DONE);
      if ((entry_q[i].state == PEND) || (entry_q[i].state == DONE)) begin
        waw_vec[i] = (entry_q[i].rd == alloc_rd);
        rs1_vec[i] = (entry_q[i].rd == chk_rs1);
        rs2_vec[i] = (entry_q[i].rd == chk_rs2);
      end
    end
  end

  assign full    = ~|idle_vec;
  assign empty   = &idle_vec;
  assign waw     = (alloc_rd != 5'd0) && (|waw_vec);
  assign chk_hit = ((chk_rs1 != 5'd0) && (|rs1_vec)) || ((chk_rs2 != 5'd0) && (|rs2_vec));

  // Lowest-index IDLE entry.
  always_comb begin
    alloc_tag = '0;
    for (int i = NB_DEPTH - 1; i >= 0; i--) begin
      if (idle_vec[i]) alloc_tag = TAG_W'(i);
    end
  end

  assign alloc_gnt = alloc_req && !full && !flush && !waw;

  lsu_nbload_rr_arb #(
    .NB_DEPTH (NB_DEPTH),
    .TAG_W    (TAG_W)
  ) u_wb_arb (
    .req_i       (done_vec),
    .ptr_i       (ptr_q),
    .gnt_valid_o (pick_valid),
    .gnt_idx_o   (pick_idx)
  );

  assign pick_rd  = entry_q[pick_idx].rd;
  // rd==0 results are silently retired, never presented on the port.
  assign wb_valid = pick_valid && (pick_rd != 5'd0) && !flush;
  assign wb_rd    = pick_rd;
  assign wb_data  = entry_q[pick_idx].data;
  assign wb_tag   = pick_idx;

`ifdef LSU_NBLOAD_ERR_EN
  assign pend_err = ret_error;
`else
  assign pend_err = 1'b0;
  logic unused_ret_error;
  assign unused_ret_error = ret_error;
`endif

  always_comb begin
    ptr_d = ptr_q;
    for (int i = 0; i < NB_DEPTH; i++) begin
      entry_d[i] = entry_q[i];
      unique case (entry_q[i].state)
        IDLE: begin
          if (alloc_gnt && (alloc_tag == TAG_W'(i))) begin
            entry_d[i].state = PEND;
            entry_d[i].rd    = alloc_rd;
          end
        end
        PEND: begin
          if (ret_valid && (ret_tag == TAG_W'(i))) begin
            if (flush || pend_err) begin
              entry_d[i].state = IDLE;
            end else begin
              entry_d[i].state = DONE;
              entry_d[i].data  = ret_data;
            end
          end else if (flush) begin
            entry_d[i].state = KILL;
          end
        end
        DONE: begin
          if (flush) begin
            entry_d[i].state = IDLE;
          end else if (pick_valid && (pick_idx == TAG_W'(i)) &&
                       (wb_ready || (entry_q[i].rd == 5'd0))) begin
            entry_d[i].state = IDLE;
          end
        end
        KILL: begin
          if (ret_valid && (ret_tag == TAG_W'(i))) entry_d[i].state = IDLE;
        end
        default: ;
      endcase
    end
    if (wb_valid && wb_ready) begin
      ptr_d = (32'(pick_idx) == NB_DEPTH - 1) ? '0 : pick_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      for (int i = 0; i < NB_DEPTH; i++) entry_q[i] <= '0;
      ptr_q <= '0;
    end else begin
      for (int i = 0; i < NB_DEPTH; i++) entry_q[i] <= entry_d[i];
      ptr_q <= ptr_d;
    end
  end

`ifdef LSU_NBLOAD_ERR_EN
  logic             err_valid_q, err_d;
  logic [TAG_W-1:0] err_tag_q;
  nbload_state_t    ret_state;

  assign ret_state = entry_q[ret_tag].state;
  // Bus errors on live loads and returns that hit IDLE/DONE entries are both reported.
  assign err_d = ret_valid && ((ret_state == IDLE) || (ret_state == DONE) ||
                               ((ret_state == PEND) && ret_error && !flush));

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      err_valid_q <= 1'b0;
      err_tag_q   <= '0;
    end else begin
      err_valid_q <= err_d;
      if (err_d) err_tag_q <= ret_tag;
    end
  end

  assign err_valid = err_valid_q;
  assign err_tag   = err_tag_q;
`else
  assign err_valid = 1'b0;
  assign err_tag   = '0;
`endif

endmodule

// File: tb/tb_lsu_nbload_ctl.sv
module tb_lsu_nbload_ctl;

  localparam int N = 4;
  localparam int M_IDLE = 0, M_PEND = 1, M_DONE = 2, M_KILL = 3;
`ifdef LSU_NBLOAD_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_l, alloc_req, alloc_gnt, ret_valid, ret_error, flush;
  logic        wb_valid, wb_ready, chk_hit, full, empty, err_valid;
  logic [4:0]  alloc_rd, wb_rd, chk_rs1, chk_rs2;
  logic [1:0]  alloc_tag, ret_tag, wb_tag, err_tag;
  logic [31:0] ret_data, wb_data;

  lsu_nbload_ctl #(.NB_DEPTH(N), .TAG_W(2)) dut (
    .clk(clk), .rst_l(rst_l),
    .alloc_req(alloc_req), .alloc_rd(alloc_rd), .alloc_gnt(alloc_gnt), .alloc_tag(alloc_tag),
    .ret_valid(ret_valid), .ret_tag(ret_tag), .ret_data(ret_data), .ret_error(ret_error),
    .flush(flush),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data), .wb_tag(wb_tag),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_hit(chk_hit),
    .full(full), .empty(empty), .err_valid(err_valid), .err_tag(err_tag)
  );

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: plain per-tag arrays updated once per clock.
  int          m_st [N];
  int          m_rd [N];
  logic [31:0] m_data [N];
  int          m_ptr, m_err_tag;
  bit          m_err;

  bit e_gnt, e_full, e_empty, e_hit, e_wbv, e_found;
  int e_tag, e_pick;

  task automatic compute_exp();
    bit waw, h1, h2;
    e_full = 1; e_empty = 1; e_tag = 0; waw = 0; h1 = 0; h2 = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (m_st[i] == M_IDLE) begin e_full = 0; e_tag = i; end
      else e_empty = 0;
      if (m_st[i] == M_PEND || m_st[i] == M_DONE) begin
        if (m_rd[i] == int'(alloc_rd)) waw = 1;
        if (m_rd[i] == int'(chk_rs1)) h1 = 1;
        if (m_rd[i] == int'(chk_rs2)) h2 = 1;
      end
    end
    waw   = waw && (alloc_rd != 0);
    e_hit = (h1 && chk_rs1 != 0) || (h2 && chk_rs2 != 0);
    e_gnt = alloc_req && !e_full && !flush && !waw;
    e_found = 0; e_pick = 0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (!e_found && m_st[j] == M_DONE) begin e_found = 1; e_pick = j; end
    end
    e_wbv = e_found && (m_rd[e_pick] != 0) && !flush;
  endtask

  task automatic model_update();
    int old [N];
    int t;
    bit err_now;
    if (!rst_l) begin
      for (int i = 0; i < N; i++) m_st[i] = M_IDLE;
      m_ptr = 0; m_err = 0; m_err_tag = 0;
      return;
    end
    for (int i = 0; i < N; i++) old[i] = m_st[i];
    t = int'(ret_tag);
    err_now = 0;
    if (ret_valid) begin
      if (old[t] == M_IDLE || old[t] == M_DONE) err_now = 1;
      if (old[t] == M_PEND && ret_error && !flush) err_now = 1;
    end
    if (flush) begin
      for (int i = 0; i < N; i++) begin
        if (old[i] == M_DONE) m_st[i] = M_IDLE;
        else if (old[i] == M_PEND) m_st[i] = (ret_valid && t == i) ? M_IDLE : M_KILL;
        else if (old[i] == M_KILL && ret_valid && t == i) m_st[i] = M_IDLE;
      end
    end else begin
      if (e_gnt) begin m_st[e_tag] = M_PEND; m_rd[e_tag] = int'(alloc_rd); end
      if (ret_valid && old[t] == M_PEND) begin
        if (ERR_EN && ret_error) m_st[t] = M_IDLE;
        else begin m_st[t] = M_DONE; m_data[t] = ret_data; end
      end else if (ret_valid && old[t] == M_KILL) begin
        m_st[t] = M_IDLE;
      end
      if (e_found && (m_rd[e_pick] == 0 || wb_ready)) begin
        m_st[e_pick] = M_IDLE;
        if (m_rd[e_pick] != 0) m_ptr = (e_pick + 1) % N;
      end
    end
    if (ERR_EN) begin
      m_err = err_now;
      if (err_now) m_err_tag = t;
    end
  endtask

  task automatic eval();
    #1;
    compute_exp();
    check_eq("alloc_gnt", alloc_gnt, e_gnt);
    if (!e_full) check_eq("alloc_tag", alloc_tag, e_tag);
    check_eq("full", full, e_full);
    check_eq("empty", empty, e_empty);
    check_eq("chk_hit", chk_hit, e_hit);
    check_eq("wb_valid", wb_valid, e_wbv);
    if (e_wbv) begin
      check_eq("wb_tag", wb_tag, e_pick);
      check_eq("wb_rd", wb_rd, m_rd[e_pick]);
      check_eq("wb_data", wb_data, m_data[e_pick]);
    end
    check_eq("err_valid", err_valid, m_err);
    check_eq("err_tag", err_tag, m_err_tag);
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle_in();
    rst_l = 1; alloc_req = 0; alloc_rd = 0; ret_valid = 0; ret_tag = 0; ret_data = 0;
    ret_error = 0; flush = 0; wb_ready = 0; chk_rs1 = 0; chk_rs2 = 0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin m_st[i] = M_IDLE; m_rd[i] = 0; m_data[i] = 0; end
    m_ptr = 0; m_err = 0; m_err_tag = 0;
    idle_in();
    rst_l = 0;
    @(negedge clk);
    tick();
    tick();
    idle_in();

    // Reset state.
    eval();
    check_eq("rst_empty", empty, 1);
    check_eq("rst_full", full, 0);
    check_eq("rst_wb_valid", wb_valid, 0);
    tick();

    // Back-to-back allocation fills the buffer.
    for (int k = 0; k < 4; k++) begin
      idle_in(); alloc_req = 1; alloc_rd = 5'(5 + k);
      eval();
      check_eq("tp_alloc_tag", alloc_tag, k);
      check_eq("tp_alloc_gnt", alloc_gnt, 1);
      tick();
    end
    idle_in(); alloc_req = 1; alloc_rd = 5'd9;
    eval();
    check_eq("tp_full", full, 1);
    check_eq("tp_full_nogrant", alloc_gnt, 0);
    tick();

    // Out-of-order returns: tag2 then tag0.
    idle_in(); ret_valid = 1; ret_tag = 2; ret_data = 32'hAAAA_0002;
    eval(); tick();
    idle_in(); ret_valid = 1; ret_tag = 0; ret_data = 32'hBBBB_0000; wb_ready = 1;
    eval();
    check_eq("tp_wb1_tag", wb_tag, 2);
    check_eq("tp_wb1_rd", wb_rd, 7);
    check_eq("tp_wb1_data", wb_data, 32'hAAAA_0002);
    tick();
    idle_in(); alloc_req = 1; alloc_rd = 5'd7; wb_ready = 1;
    eval();
    check_eq("tp_realloc_gnt", alloc_gnt, 1);
    check_eq("tp_realloc_tag", alloc_tag, 2);
    check_eq("tp_wb2_tag", wb_tag, 0);
    check_eq("tp_wb2_data", wb_data, 32'hBBBB_0000);
    tick();

    // WAW stall and hazard check.
    idle_in(); alloc_req = 1; alloc_rd = 5'd6; chk_rs1 = 5'd6;
    eval();
    check_eq("tp_waw", alloc_gnt, 0);
    check_eq("tp_hit", chk_hit, 1);
    tick();
    idle_in(); alloc_req = 1; alloc_rd = 5'd0;
    eval(); tick();
    idle_in();
    eval();
    check_eq("tp_hit_x0", chk_hit, 0);
    tick();

    // Writeback backpressure holds payload, then round-robin resumes.
    idle_in(); ret_valid = 1; ret_tag = 1; ret_data = 32'hCCCC_0001;
    eval(); tick();
    idle_in(); ret_valid = 1; ret_tag = 3; ret_data = 32'hDDDD_0003;
    eval(); tick();
    for (int k = 0; k < 3; k++) begin
      idle_in();
      eval();
      check_eq("tp_hold_valid", wb_valid, 1);
      check_eq("tp_hold_tag", wb_tag, 1);
      check_eq("tp_hold_data", wb_data, 32'hCCCC_0001);
      tick();
    end
    idle_in(); wb_ready = 1;
    eval(); tick();
    idle_in(); wb_ready = 1;
    eval();
    check_eq("tp_rr_tag", wb_tag, 3);
    check_eq("tp_rr_rd", wb_rd, 8);
    tick();

    // rd==0 result retires without writeback.
    idle_in(); ret_valid = 1; ret_tag = 0; ret_data = 32'h1234_5678;
    eval(); tick();
    idle_in(); wb_ready = 1;
    eval();
    check_eq("tp_x0_nowb", wb_valid, 0);
    tick();

    // Flush: DONE dropped, PEND killed, late return discarded.
    idle_in(); alloc_req = 1; alloc_rd = 5'd9;
    eval(); tick();
    idle_in(); ret_valid = 1; ret_tag = 0; ret_data = 32'h5555_0000;
    eval(); tick();
    idle_in(); flush = 1; wb_ready = 1; alloc_req = 1; alloc_rd = 5'd12;
    eval();
    check_eq("tp_flush_nowb", wb_valid, 0);
    check_eq("tp_flush_nogrant", alloc_gnt, 0);
    tick();
    idle_in(); ret_valid = 1; ret_tag = 2; ret_data = 32'hDEAD_BEEF; wb_ready = 1;
    eval();
    check_eq("tp_kill_notempty", empty, 0);
    tick();
    idle_in();
    eval();
    check_eq("tp_kill_empty", empty, 1);
    tick();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      int live [$];
      idle_in();
      rst_l     = ($urandom_range(0, 199) != 0);
      alloc_req = ($urandom_range(0, 9) < 7);
      alloc_rd  = 5'($urandom_range(0, 7));
      ret_valid = ($urandom_range(0, 1) == 1);
      for (int i = 0; i < N; i++) if (m_st[i] == M_PEND || m_st[i] == M_KILL) live.push_back(i);
      if (live.size() > 0 && $urandom_range(0, 4) != 0)
        ret_tag = 2'(live[$urandom_range(0, live.size() - 1)]);
      else
        ret_tag = 2'($urandom_range(0, 3));
      ret_data  = $urandom;
      ret_error = ($urandom_range(0, 7) == 0);
      flush     = ($urandom_range(0, 19) == 0);
      wb_ready  = ($urandom_range(0, 9) < 6);
      chk_rs1   = 5'($urandom_range(0, 7));
      chk_rs2   = 5'($urandom_range(0, 7));
      eval();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
